// File: rtl/event_fifo_writer.sv
// Fabric event producer: buffers 32-bit event words locally and drains them into the
// fifo_1_in Avalon-MM write slave. Optional macro EVENT_TIMESTAMP_EN stamps each word.
module event_fifo_writer #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ev_valid,
    input  logic [31:0]       ev_data,
    output logic              ev_ready,
    output logic              av_address,
    output logic              av_write,
    output logic [31:0]       av_writedata,
    input  logic              av_waitrequest,
    output logic [PTR_W:0]    pending,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W:0]    count;
    logic [31:0]       store_word;
    logic              push;
    logic              drop;
    logic              pop;

`ifdef EVENT_TIMESTAMP_EN
    logic [15:0] ts;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= '0;
        end else begin
            ts <= ts + 16'd1;
        end
    end

    assign store_word = {ts, ev_data[15:0]};
`else
    assign store_word = ev_data;
`endif

    // Full is decoded from the registered count, so a full buffer refuses a push even while popping.
    assign ev_ready   = (count != FULL_COUNT);
    assign push       = ev_valid & ev_ready;
    assign drop       = ev_valid & ~ev_ready;
    assign av_address = 1'b0;
    assign av_write   = (state == XFER);
    assign pending    = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= store_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (!av_waitrequest) begin
                    if (count != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            av_writedata <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                av_writedata <= mem[rptr];
                rptr         <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating: stays at all-ones once reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != {DROP_W{1'b1}})) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_event_fifo_writer.sv
// Directed self-checking bench for event_fifo_writer (default build, no timestamps).
module tb_event_fifo_writer;

    logic        clk;
    logic        reset;
    logic        ev_valid;
    logic [31:0] ev_data;
    logic        ev_ready;
    logic        av_address;
    logic        av_write;
    logic [31:0] av_writedata;
    logic        av_waitrequest;
    logic [3:0]  pending;
    logic [15:0] drop_count;

    int checks;
    int errors;

    event_fifo_writer #(.DEPTH(8), .PTR_W(3), .DROP_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .ev_valid       (ev_valid),
        .ev_data        (ev_data),
        .ev_ready       (ev_ready),
        .av_address     (av_address),
        .av_write       (av_write),
        .av_writedata   (av_writedata),
        .av_waitrequest (av_waitrequest),
        .pending        (pending),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic wr);
        ev_valid       = valid;
        ev_data        = data;
        av_waitrequest = wr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("rst_av_write", {31'd0, av_write}, 32'd0);
        checkOutput("rst_writedata", av_writedata, 32'd0);
        checkOutput("rst_pending", {28'd0, pending}, 32'd0);
        checkOutput("rst_drop", {16'd0, drop_count}, 32'd0);
        checkOutput("rst_ev_ready", {31'd0, ev_ready}, 32'd1);
        checkOutput("rst_address", {31'd0, av_address}, 32'd0);
        reset = 1'b0;
        tick();

        // Single event, no stall
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("single_pending1", {28'd0, pending}, 32'd1);
        checkOutput("single_nowrite_yet", {31'd0, av_write}, 32'd0);
        tick();
        checkOutput("single_write", {31'd0, av_write}, 32'd1);
        checkOutput("single_data", av_writedata, 32'hDEADBEEF);
        checkOutput("single_address", {31'd0, av_address}, 32'd0);
        checkOutput("single_pending0", {28'd0, pending}, 32'd0);
        tick();
        checkOutput("single_write_done", {31'd0, av_write}, 32'd0);
        tick();
        checkOutput("single_write_idle", {31'd0, av_write}, 32'd0);

        // Stall hold with three words
        applyStimulus(1'b1, 32'h11, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h22, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h33, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("stall_pending", {28'd0, pending}, 32'd2);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_write", {31'd0, av_write}, 32'd1);
            checkOutput("stall_data", av_writedata, 32'h11);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("stall_rel_data0", av_writedata, 32'h11);
        tick();
        checkOutput("stall_rel_write1", {31'd0, av_write}, 32'd1);
        checkOutput("stall_rel_data1", av_writedata, 32'h22);
        tick();
        checkOutput("stall_rel_write2", {31'd0, av_write}, 32'd1);
        checkOutput("stall_rel_data2", av_writedata, 32'h33);
        tick();
        checkOutput("stall_rel_idle", {31'd0, av_write}, 32'd0);
        checkOutput("stall_rel_pending", {28'd0, pending}, 32'd0);

        // Overflow: 12 pushes under stall, 9 accepted, 3 dropped
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b1);
            tick();
            if (i == 9) begin
                checkOutput("ovf_ready_full", {31'd0, ev_ready}, 32'd0);
                checkOutput("ovf_pending_full", {28'd0, pending}, 32'd8);
            end
        end
        checkOutput("ovf_drop3", {16'd0, drop_count}, 32'd3);
        checkOutput("ovf_pending8", {28'd0, pending}, 32'd8);
        checkOutput("ovf_inflight", av_writedata, 32'd1);
        // Full buffer refuses a push even on the cycle it pops
        applyStimulus(1'b1, 32'h99, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("ovf_popfull_drop", {16'd0, drop_count}, 32'd4);
        checkOutput("ovf_popfull_pending", {28'd0, pending}, 32'd7);
        for (int k = 2; k <= 9; k++) begin
            checkOutput("ovf_order_write", {31'd0, av_write}, 32'd1);
            checkOutput("ovf_order_data", av_writedata, 32'(k));
            tick();
        end
        checkOutput("ovf_done_write", {31'd0, av_write}, 32'd0);
        checkOutput("ovf_done_pending", {28'd0, pending}, 32'd0);

        // Reset mid-transfer
        applyStimulus(1'b1, 32'hA1, 1'b1);
        tick();
        applyStimulus(1'b1, 32'hA2, 1'b1);
        tick();
        applyStimulus(1'b1, 32'hA3, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("mid_write_before", {31'd0, av_write}, 32'd1);
        checkOutput("mid_pending_before", {28'd0, pending}, 32'd2);
        reset = 1'b1;
        tick();
        checkOutput("mid_write_after", {31'd0, av_write}, 32'd0);
        checkOutput("mid_pending_after", {28'd0, pending}, 32'd0);
        checkOutput("mid_drop_after", {16'd0, drop_count}, 32'd0);
        checkOutput("mid_ready_after", {31'd0, ev_ready}, 32'd1);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mid_no_stale", {31'd0, av_write}, 32'd0);
        end

        // Saturation: fill (1 in flight + 8 buffered), then 65540 drops
        applyStimulus(1'b1, 32'h5A5A5A5A, 1'b1);
        for (int i = 0; i < 9 + 65534; i++) begin
            tick();
        end
        checkOutput("sat_fffe", {16'd0, drop_count}, 32'h0000FFFE);
        tick();
        checkOutput("sat_ffff", {16'd0, drop_count}, 32'h0000FFFF);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checkOutput("sat_hold", {16'd0, drop_count}, 32'h0000FFFF);
        checkOutput("sat_pending", {28'd0, pending}, 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/event_fifo_writer.md
Name: event_fifo_writer

Overview:
- Fabric-side producer feeding the fifo_1_in Avalon-MM write slave of the SoC.
- Accepts 32-bit game/input event words from fabric logic one per cycle and buffers them in a small local FIFO.
- Drains the buffer into the SoC FIFO with Avalon write/waitrequest handshaking, so the HPS reads events in order.
- Counts events lost to local overflow.

Parameters:
- DEPTH, 8, local buffer entries; power of two, at least 2.
- PTR_W, 3, log2(DEPTH); pointer width.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; same clock as the fifo_1_in interface.
- reset  input  1  synchronous, active-high reset.
- ev_valid  input  1  event strobe; the source does not stall.
- ev_data  input  32  event word, sampled when ev_valid=1.
- ev_ready  output  1  1 when the local buffer is not full; informational only.
- av_address  output  1  Avalon address to fifo_1_in; constant 0.
- av_write  output  1  Avalon write request.
- av_writedata  output  32  Avalon write data.
- av_waitrequest  input  1  slave stall from fifo_1_in.
- pending  output  PTR_W+1  number of words in the local buffer (0..DEPTH).
- drop_count  output  DROP_W  events discarded because the buffer was full; saturating.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - On a reset cycle: all outputs 0 at the next edge except ev_ready=1. av_write=0, av_writedata=0, pending=0, drop_count=0. Pointers are cleared and the state goes to IDLE.
  - Reset mid-transfer: av_write drops at that edge; the in-flight word and all buffered words are discarded.
- Local buffer:
  - Circular, DEPTH entries, with write/read pointers of PTR_W bits that wrap modulo DEPTH.
  - Count is PTR_W+1 bits.
  - ev_ready = (count != DEPTH), decoded from the registered count.
- Push: ev_valid & ev_ready stores the word at wptr; wptr is incremented.
- Drop: ev_valid & !ev_ready increments drop_count, saturating at all-ones and never wrapping. The word is discarded.
- Pop: occurs when the FSM loads the head into av_writedata.
- Same-cycle push and pop: count is unchanged. Because ev_ready uses the registered count, a full buffer refuses the push even in a cycle where a pop occurs.
- FSM, 2 states:
  - IDLE: av_write=0. If count!=0, pop the head into av_writedata, set av_write=1, go to XFER.
  - XFER: av_write=1. While av_waitrequest=1, hold av_address, av_write and av_writedata stable; no pop occurs.
    - When av_waitrequest=0, the transfer completes at that edge.
    - If count!=0 at the same edge, pop the next word into av_writedata and keep av_write=1 (back-to-back, one word/cycle).
    - Otherwise clear av_write and go to IDLE.
- Latency: an event pushed into an empty buffer at edge N appears with av_write=1 after edge N+1. With waitrequest=0, it completes at edge N+2.
- pending counts the local buffer only, not the word held in av_writedata.
- Ordering: strict FIFO. No word is duplicated or reordered across waitrequest stalls.

Optional Feature:
- Macro EVENT_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit cycle counter, cleared by reset, increments every clk and wraps 0xFFFF->0.
  - The stored word is {ts[15:0], ev_data[15:0]}, where ts is the counter value at the push edge.
  - Dropped events still increment drop_count.
- Undefined: no counter is instantiated and ev_data is stored verbatim.

Test Plan:
- Single event: reset, then ev_data=0xDEADBEEF for 1 cycle with waitrequest=0 -> av_write=1 for exactly one cycle carrying 0xDEADBEEF, av_address=0; pending returns to 0.
- Stall hold: push 0x11,0x22,0x33 with waitrequest=1 for 5 cycles -> av_writedata stays 0x11 and av_write stays 1 throughout. After release, words 0x11,0x22,0x33 complete on consecutive cycles.
- Overflow: waitrequest=1, push 12 events 1..12 back-to-back -> 1 in flight, 8 buffered, ev_ready=0 after the 9th push, drop_count=3. After release, the slave sees 1..9 in order.
- Saturation: force 65540 drops with DROP_W=16 -> drop_count holds 0xFFFF.
- Reset mid-transfer: reset asserted while av_write=1 and waitrequest=1 -> av_write=0, pending=0, drop_count=0 at the next edge. No stale word is written after reset.
- EVENT_TIMESTAMP_EN defined: push ev_data=0xAAAA5555 at cycle 100 after reset release -> written word = 0x00645555 (cycle count at the push edge).
